// File: rtl/ahrs_pkg.sv
// rtl/ahrs_pkg.sv - shared constants, channel map and FSM type for the AHRS frame scheduler
// Holds the channel count, the channel index map, the status counter width and the scheduler state type.
package ahrs_pkg;

    localparam int NUM_CH = 13;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    // Host channel order within one frame
    localparam logic [IDX_W-1:0] CH_ACCX  = 4'd0;
    localparam logic [IDX_W-1:0] CH_ACCY  = 4'd1;
    localparam logic [IDX_W-1:0] CH_ACCZ  = 4'd2;
    localparam logic [IDX_W-1:0] CH_GYROX = 4'd3;
    localparam logic [IDX_W-1:0] CH_GYROY = 4'd4;
    localparam logic [IDX_W-1:0] CH_GYROZ = 4'd5;
    localparam logic [IDX_W-1:0] CH_MAGX  = 4'd6;
    localparam logic [IDX_W-1:0] CH_MAGY  = 4'd7;
    localparam logic [IDX_W-1:0] CH_MAGZ  = 4'd8;
    localparam logic [IDX_W-1:0] CH_QA    = 4'd9;
    localparam logic [IDX_W-1:0] CH_QB    = 4'd10;
    localparam logic [IDX_W-1:0] CH_QC    = 4'd11;
    localparam logic [IDX_W-1:0] CH_QS    = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        REQ   = 2'd2,
        WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/ahrs_frame_scheduler_if.sv
// rtl/ahrs_frame_scheduler_if.sv - datapath request and channel FIFO write bundle
// Signals: src_req/src_idx (word request), src_valid/src_data (datapath reply),
//          fifo_wren (one-hot per channel), fifo_data (shared write data).
// master = scheduler side, slave = datapath/FIFO side.
interface ahrs_frame_scheduler_if
    import ahrs_pkg::*;
#(
    parameter int NUM_CH = ahrs_pkg::NUM_CH
);
    logic              src_req;
    logic [IDX_W-1:0]  src_idx;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic [NUM_CH-1:0] fifo_wren;
    logic [DATA_W-1:0] fifo_data;

    modport master (
        output src_req, src_idx, fifo_wren, fifo_data,
        input  src_valid, src_data
    );

    modport slave (
        input  src_req, src_idx, fifo_wren, fifo_data,
        output src_valid, src_data
    );
endinterface

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit saturating event counter
// Ports: clk, clr (synchronous clear, wins over inc), inc (count enable), count (holds at all-ones).
module sat_counter16
    import ahrs_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ahrs_frame_scheduler.sv
// rtl/ahrs_frame_scheduler.sv - per-frame scheduler moving fusion results into host channel FIFOs
// Ports: bus_clk, bus_rst (sync, active-high), frame_tick (frame start strobe),
//        ch_open/ch_full (per-channel host state), bus (master side of request/FIFO bundle),
//        busy, frame_cnt/overrun_cnt/drop_cnt/timeout_cnt (saturating status).
module ahrs_frame_scheduler
    import ahrs_pkg::*;
#(
    parameter int NUM_CH  = ahrs_pkg::NUM_CH,
    parameter int TIMEOUT = 255
) (
    input  logic                   bus_clk,
    input  logic                   bus_rst,
    input  logic                   frame_tick,
    input  logic [NUM_CH-1:0]      ch_open,
    input  logic [NUM_CH-1:0]      ch_full,
    ahrs_frame_scheduler_if.master bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       overrun_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       timeout_cnt
);

    // The wait counter runs 0..TIMEOUT-1, so REQ lasts exactly TIMEOUT cycles on a timeout.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NUM_CH-1:0] ONE_HOT = NUM_CH'(1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] open_mask_q, open_mask_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic advance;
    logic frame_done;
    logic tmo_hit;
    logic drop_hit;
    logic overrun;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        open_mask_d   = open_mask_q;
        tmo_d         = tmo_q;
        data_d        = data_q;
        advance       = 1'b0;
        frame_done    = 1'b0;
        tmo_hit       = 1'b0;
        drop_hit      = 1'b0;
        bus.src_req   = 1'b0;
        bus.src_idx   = '0;
        bus.fifo_wren = '0;

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    open_mask_d = ch_open;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (open_mask_q[idx_q]) begin
                    tmo_d   = '0;
                    state_d = REQ;
                end else begin
                    advance = 1'b1;
                end
            end
            REQ: begin
                bus.src_req = 1'b1;
                bus.src_idx = idx_q;
                if (bus.src_valid) begin
                    data_d  = bus.src_data;
                    state_d = WRITE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    advance = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WRITE: begin
                // Live ch_open is used here: a channel closed since the snapshot drops silently.
                if (ch_open[idx_q]) begin
                    if (ch_full[idx_q]) begin
                        drop_hit = 1'b1;
                    end else begin
                        bus.fifo_wren = ONE_HOT << idx_q;
                    end
                end
                advance = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q == IDX_W'(NUM_CH - 1)) begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = SCAN;
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            open_mask_q <= '0;
            tmo_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            open_mask_q <= open_mask_d;
            tmo_q       <= tmo_d;
            data_q      <= data_d;
        end
    end

    assign bus.fifo_data = data_q;
    assign busy          = (state_q != IDLE);
    // Includes the last cycle of a frame, whose next state is already IDLE.
    assign overrun       = frame_tick && (state_q != IDLE);

    sat_counter16 u_frame_cnt (
        .clk   (bus_clk),
        .clr   (bus_rst),
        .inc   (frame_done),
        .count (frame_cnt)
    );

    sat_counter16 u_overrun_cnt (
        .clk   (bus_clk),
        .clr   (bus_rst),
        .inc   (overrun),
        .count (overrun_cnt)
    );

    sat_counter16 u_drop_cnt (
        .clk   (bus_clk),
        .clr   (bus_rst),
        .inc   (drop_hit),
        .count (drop_cnt)
    );

    sat_counter16 u_timeout_cnt (
        .clk   (bus_clk),
        .clr   (bus_rst),
        .inc   (tmo_hit),
        .count (timeout_cnt)
    );

endmodule

// File: tb/tb_ahrs_frame_scheduler.sv
// tb/tb_ahrs_frame_scheduler.sv - directed self-checking bench for ahrs_frame_scheduler
module tb_ahrs_frame_scheduler;

    logic        bus_clk = 1'b0;
    logic        bus_rst;
    logic        frame_tick;
    logic [12:0] ch_open;
    logic [12:0] ch_full;
    logic        busy;
    logic [15:0] frame_cnt, overrun_cnt, drop_cnt, timeout_cnt;

    int checks   = 0;
    int failures = 0;

    // Per-frame record filled by run_frame
    int          n_wr;
    int          wr_ch   [32];
    logic [31:0] wr_data [32];
    int          req_cyc [16];
    logic [15:0] req_seen;
    int          first_req;
    int          first_wr;
    int          frame_cycles;
    bit          timed_out;
    bit          wren_multi;

    ahrs_frame_scheduler_if #(.NUM_CH(13)) sif ();

    ahrs_frame_scheduler #(.NUM_CH(13), .TIMEOUT(255)) dut (
        .bus_clk     (bus_clk),
        .bus_rst     (bus_rst),
        .frame_tick  (frame_tick),
        .ch_open     (ch_open),
        .ch_full     (ch_full),
        .bus         (sif),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .overrun_cnt (overrun_cnt),
        .drop_cnt    (drop_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    // Starts one frame and services it; the datapath answers in the second REQ cycle
    // with 0x1000+idx, except for silent_ch which never answers.
    task automatic run_frame(input logic [12:0] open, input logic [12:0] full,
                             input int silent_ch, input int budget);
        int cyc;
        int age;
        n_wr = 0; req_seen = '0; first_req = -1; first_wr = -1; wren_multi = 1'b0;
        for (int i = 0; i < 16; i++) req_cyc[i] = 0;
        @(posedge bus_clk); #1;
        ch_open = open; ch_full = full; frame_tick = 1'b1;
        @(posedge bus_clk); #1;
        frame_tick = 1'b0;
        cyc = 1; age = 0; timed_out = 1'b1;
        while (cyc <= budget) begin
            if (sif.src_req) begin
                sif.src_valid = (age >= 1) && (int'(sif.src_idx) != silent_ch);
                sif.src_data  = 32'h1000 + 32'(sif.src_idx);
                req_cyc[sif.src_idx]++;
                req_seen[sif.src_idx] = 1'b1;
                if (first_req < 0) first_req = cyc;
                age++;
            end else begin
                sif.src_valid = 1'b0;
                age = 0;
            end
            #1;
            if (sif.fifo_wren != '0) begin
                if (!$onehot(sif.fifo_wren)) wren_multi = 1'b1;
                if (first_wr < 0) first_wr = cyc;
                for (int i = 0; i < 13; i++) begin
                    if (sif.fifo_wren[i] && n_wr < 32) begin
                        wr_ch[n_wr]   = i;
                        wr_data[n_wr] = sif.fifo_data;
                    end
                end
                n_wr++;
            end
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge bus_clk); #1;
            cyc++;
        end
        sif.src_valid = 1'b0;
        frame_cycles  = cyc;
    endtask

    task automatic test_reset();
        bus_rst = 1'b1; frame_tick = 1'b1; ch_open = 13'h1FFF; ch_full = '0;
        sif.src_valid = 1'b0; sif.src_data = '0;
        repeat (3) @(posedge bus_clk);
        #1;
        bus_rst = 1'b0; frame_tick = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (sif.src_req !== 1'b0) begin failures++; $display("FAIL reset_src_req got=%0b exp=0", sif.src_req); end
        checks++; if (sif.src_idx !== 4'd0) begin failures++; $display("FAIL reset_src_idx got=%0d exp=0", sif.src_idx); end
        checks++; if (sif.fifo_wren !== 13'd0) begin failures++; $display("FAIL reset_fifo_wren got=%h exp=0", sif.fifo_wren); end
        checks++; if (sif.fifo_data !== 32'd0) begin failures++; $display("FAIL reset_fifo_data got=%h exp=0", sif.fifo_data); end
        checks++; if ({frame_cnt, overrun_cnt, drop_cnt, timeout_cnt} !== 64'd0) begin
            failures++; $display("FAIL reset_counters got=%h/%h/%h/%h exp=0", frame_cnt, overrun_cnt, drop_cnt, timeout_cnt);
        end
        @(posedge bus_clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_tick_ignored busy got=%0b exp=0", busy); end
        checks++; if (overrun_cnt !== 16'd0) begin failures++; $display("FAIL reset_tick_overrun got=%0d exp=0", overrun_cnt); end
    endtask

    task automatic test_all_open();
        run_frame(13'h1FFF, 13'h0000, -1, 200);
        checks++; if (timed_out) begin failures++; $display("FAIL all_open_timeout got=timeout exp=frame_end"); end
        checks++; if (first_req != 2) begin failures++; $display("FAIL all_open_req_latency got=%0d exp=2", first_req); end
        checks++; if (first_wr != 4) begin failures++; $display("FAIL all_open_wr_latency got=%0d exp=4", first_wr); end
        checks++; if (n_wr != 13) begin failures++; $display("FAIL all_open_n_wr got=%0d exp=13", n_wr); end
        for (int ch = 0; ch < 13; ch++) begin
            checks++;
            if (wr_ch[ch] != ch || wr_data[ch] !== 32'h1000 + 32'(ch)) begin
                failures++; $display("FAIL all_open_write%0d got=ch%0d/%h exp=ch%0d/%h", ch, wr_ch[ch], wr_data[ch], ch, 32'h1000 + 32'(ch));
            end
        end
        checks++; if (frame_cycles != 53) begin failures++; $display("FAIL all_open_frame_len got=%0d exp=53", frame_cycles); end
        checks++; if (wren_multi) begin failures++; $display("FAIL all_open_onehot got=multi exp=onehot"); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL all_open_frame_cnt got=%0d exp=1", frame_cnt); end
        checks++; if (sif.fifo_data !== 32'h0000_100C) begin failures++; $display("FAIL all_open_data_hold got=%h exp=0000100c", sif.fifo_data); end
        checks++; if (sif.fifo_wren !== 13'd0) begin failures++; $display("FAIL all_open_idle_wren got=%h exp=0", sif.fifo_wren); end
    endtask

    task automatic test_sparse();
        run_frame(13'h0005, 13'h0000, -1, 200);
        checks++; if (req_seen !== 16'h0005) begin failures++; $display("FAIL sparse_req_seen got=%h exp=0005", req_seen); end
        checks++; if (n_wr != 2) begin failures++; $display("FAIL sparse_n_wr got=%0d exp=2", n_wr); end
        checks++; if (wr_ch[0] != 0 || wr_data[0] !== 32'h1000) begin failures++; $display("FAIL sparse_wr0 got=ch%0d/%h exp=ch0/00001000", wr_ch[0], wr_data[0]); end
        checks++; if (wr_ch[1] != 2 || wr_data[1] !== 32'h1002) begin failures++; $display("FAIL sparse_wr1 got=ch%0d/%h exp=ch2/00001002", wr_ch[1], wr_data[1]); end
        checks++; if (frame_cycles != 20) begin failures++; $display("FAIL sparse_frame_len got=%0d exp=20", frame_cycles); end
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL sparse_frame_cnt got=%0d exp=2", frame_cnt); end
    endtask

    task automatic test_full();
        int e;
        run_frame(13'h1FFF, 13'h0010, -1, 200);
        checks++; if (n_wr != 12) begin failures++; $display("FAIL full_n_wr got=%0d exp=12", n_wr); end
        e = 0;
        for (int ch = 0; ch < 13; ch++) begin
            if (ch != 4) begin
                checks++;
                if (wr_ch[e] != ch || wr_data[e] !== 32'h1000 + 32'(ch)) begin
                    failures++; $display("FAIL full_write%0d got=ch%0d/%h exp=ch%0d", e, wr_ch[e], wr_data[e], ch);
                end
                e++;
            end
        end
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL full_drop_cnt got=%0d exp=1", drop_cnt); end
        checks++; if (frame_cycles != 53) begin failures++; $display("FAIL full_frame_len got=%0d exp=53", frame_cycles); end
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL full_frame_cnt got=%0d exp=3", frame_cnt); end
        ch_full = '0;
    endtask

    task automatic test_timeout();
        int e;
        run_frame(13'h1FFF, 13'h0000, 7, 400);
        checks++; if (req_cyc[7] != 255) begin failures++; $display("FAIL timeout_req_len got=%0d exp=255", req_cyc[7]); end
        checks++; if (timeout_cnt !== 16'd1) begin failures++; $display("FAIL timeout_cnt got=%0d exp=1", timeout_cnt); end
        checks++; if (req_cyc[8] != 2) begin failures++; $display("FAIL timeout_next_ch got=%0d exp=2", req_cyc[8]); end
        checks++; if (n_wr != 12) begin failures++; $display("FAIL timeout_n_wr got=%0d exp=12", n_wr); end
        e = 0;
        for (int ch = 0; ch < 13; ch++) begin
            if (ch != 7) begin
                checks++;
                if (wr_ch[e] != ch) begin failures++; $display("FAIL timeout_write%0d got=ch%0d exp=ch%0d", e, wr_ch[e], ch); end
                e++;
            end
        end
        checks++; if (frame_cycles != 305) begin failures++; $display("FAIL timeout_frame_len got=%0d exp=305", frame_cycles); end
        checks++; if (frame_cnt !== 16'd4) begin failures++; $display("FAIL timeout_frame_cnt got=%0d exp=4", frame_cnt); end
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL timeout_drop_cnt got=%0d exp=1", drop_cnt); end
    endtask

    task automatic test_overrun();
        @(posedge bus_clk); #1;
        ch_open = '0; ch_full = '0; frame_tick = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge bus_clk); #1;
            frame_tick = (c == 5) || (c == 13);
            if (c == 7) begin
                checks++; if (overrun_cnt !== 16'd1) begin failures++; $display("FAIL overrun_mid got=%0d exp=1", overrun_cnt); end
            end
            if (c == 14) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_end_busy got=%0b exp=0", busy); end
                checks++; if (overrun_cnt !== 16'd2) begin failures++; $display("FAIL overrun_last_cycle got=%0d exp=2", overrun_cnt); end
                checks++; if (frame_cnt !== 16'd5) begin failures++; $display("FAIL overrun_frame_cnt got=%0d exp=5", frame_cnt); end
            end
            if (c == 15) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_no_restart got=%0b exp=0", busy); end
            end
        end
        frame_tick = 1'b0;
        force dut.u_overrun_cnt.count = 16'hFFFF;
        @(posedge bus_clk); #1;
        release dut.u_overrun_cnt.count;
        @(posedge bus_clk); #1;
        frame_tick = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge bus_clk); #1;
            frame_tick = (c == 3);
        end
        frame_tick = 1'b0;
        checks++; if (overrun_cnt !== 16'hFFFF) begin failures++; $display("FAIL overrun_saturate got=%h exp=ffff", overrun_cnt); end
        checks++; if (frame_cnt !== 16'd6) begin failures++; $display("FAIL overrun_sat_frame_cnt got=%0d exp=6", frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        bit bad;
        @(posedge bus_clk); #1;
        ch_open = 13'h1FFF; ch_full = '0; frame_tick = 1'b1;
        @(posedge bus_clk); #1;
        frame_tick = 1'b0;
        found = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (sif.src_req && sif.src_idx == 4'd3) begin
                found = 1'b1;
                break;
            end
            sif.src_valid = sif.src_req;
            sif.src_data  = 32'hA000 + 32'(sif.src_idx);
            @(posedge bus_clk); #1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rst_mid_reach_ch3 got=not_reached exp=reached"); end
        bus_rst = 1'b1; sif.src_valid = 1'b1; sif.src_data = 32'hDEAD_BEEF;
        @(posedge bus_clk); #1;
        bus_rst = 1'b0; sif.src_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
        checks++; if (sif.src_req !== 1'b0) begin failures++; $display("FAIL rst_mid_src_req got=%0b exp=0", sif.src_req); end
        checks++; if (sif.fifo_data !== 32'd0) begin failures++; $display("FAIL rst_mid_fifo_data got=%h exp=0", sif.fifo_data); end
        checks++; if (overrun_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            failures++; $display("FAIL rst_mid_counters got=%h/%h exp=0/0", overrun_cnt, frame_cnt);
        end
        bad = (sif.fifo_wren != '0);
        repeat (3) begin
            @(posedge bus_clk); #1;
            if (sif.fifo_wren != '0 || busy) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rst_mid_no_write got=activity exp=idle"); end
        run_frame(13'h1FFF, 13'h0000, -1, 200);
        checks++; if (first_req != 2) begin failures++; $display("FAIL rst_mid_restart_latency got=%0d exp=2", first_req); end
        checks++; if (n_wr != 13 || wr_ch[0] != 0) begin failures++; $display("FAIL rst_mid_restart got=%0d writes first ch%0d exp=13 first ch0", n_wr, wr_ch[0]); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL rst_mid_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    initial begin
        bus_rst = 1'b1; frame_tick = 1'b0; ch_open = '0; ch_full = '0;
        sif.src_valid = 1'b0; sif.src_data = '0;
        test_reset();
        test_all_open();
        test_sparse();
        test_full();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahrs_frame_scheduler.md
AHRS_FRAME_SCHEDULER -- requirements
Module: ahrs_frame_scheduler

Interface
REQ-001 Parameter NUM_CH, default 13, sets the number of host read channels serviced per frame.
REQ-002 Parameter TIMEOUT, default 255, sets the maximum cycles the block waits for src_valid per channel.
REQ-003 bus_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 bus_rst  in  1  reset, synchronous, active-high.
REQ-005 frame_tick  in  1  one-cycle strobe that starts a frame.
REQ-006 ch_open  in  NUM_CH  per-channel host file open.
REQ-007 ch_full  in  NUM_CH  per-channel downstream FIFO full.
REQ-008 src_req  out  1  request for one result word from the fusion datapath.
REQ-009 src_idx  out  4  channel index requested; valid while src_req=1.
REQ-010 src_valid  in  1  datapath word valid; sampled only while src_req=1.
REQ-011 src_data  in  32  datapath word.
REQ-012 fifo_wren  out  NUM_CH  one-hot write enable to the channel FIFOs.
REQ-013 fifo_data  out  32  write data; shared by all channels.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_cnt, overrun_cnt, drop_cnt, timeout_cnt  out  16 each  saturating status counters.

Function
REQ-016 Channel order SHALL be 0 accx, 1 accy, 2 accz, 3 gyrox, 4 gyroy, 5 gyroz, 6 magx, 7 magy, 8 magz, 9 qa, 10 qb, 11 qc, 12 qs.
REQ-017 FSM states SHALL be IDLE, SCAN, REQ and WRITE.
REQ-018 IDLE: on frame_tick=1, snapshot ch_open into open_mask, set idx=0 and go to SCAN.
REQ-019 SCAN (one cycle per channel): if open_mask[idx]=1, go to REQ; otherwise advance.
REQ-020 Advance: if idx=NUM_CH-1, increment frame_cnt and go to IDLE; otherwise increment idx and go to SCAN.
REQ-021 REQ: src_req=1 and src_idx=idx; when src_valid=1, capture src_data into a register and go to WRITE.
REQ-022 REQ timeout: if src_valid stays 0 for TIMEOUT consecutive REQ cycles, increment timeout_cnt and advance without writing.
REQ-023 WRITE (one cycle): if ch_open[idx]=1 and ch_full[idx]=0, drive fifo_wren[idx]=1 with the captured word on fifo_data, then advance.
REQ-024 WRITE with ch_full[idx]=1: discard the word, increment drop_cnt and advance; the block never stalls on full.
REQ-025 WRITE with ch_open[idx]=0 (channel closed mid-frame): discard silently, no counter change, then advance.
REQ-026 Latency: a frame_tick at cycle T with channel 0 open SHALL give src_req=1 at T+2; src_valid at cycle V SHALL give fifo_wren at V+1.
REQ-027 frame_tick in any state other than IDLE, including the cycle that returns to IDLE, SHALL be ignored and SHALL increment overrun_cnt.
REQ-028 All counters SHALL saturate at 0xFFFF and never wrap.
REQ-029 fifo_wren SHALL be all-zero outside WRITE and at most one-hot in WRITE.
REQ-030 fifo_data SHALL hold the last captured word when no write is in progress.

Reset
REQ-031 bus_rst=1 SHALL force state IDLE, idx=0, open_mask=0, all counters=0, src_req=0, src_idx=0, fifo_wren=0, fifo_data=0 and busy=0 on the next edge.
REQ-032 Reset asserted mid-frame SHALL abort the frame without further writes; a frame_tick coincident with reset SHALL be ignored.

Structure
REQ-033 Shared package ahrs_pkg SHALL hold NUM_CH, the channel-index constants, the FSM state type and the counter width.
REQ-034 A sub-module sat_counter16 (increment enable, synchronous clear, saturate) SHALL be instantiated four times.

Verification
REQ-035 All 13 channels open, src_valid one cycle after each src_req with data 0x1000+idx -> 13 writes in order 0..12 with matching data; frame_cnt=1.
REQ-036 ch_open=0x0005 -> writes only to channels 0 and 2; src_idx never shows 1 or 3..12; frame completes.
REQ-037 ch_full[4]=1 for the whole frame -> no fifo_wren[4]; drop_cnt=1; the other 12 channels are written.
REQ-038 Channel 7 src_valid never asserted, TIMEOUT=255 -> src_req held 255 cycles, timeout_cnt=1, then the scheduler proceeds to channel 8.
REQ-039 Second frame_tick 5 cycles after the first -> overrun_cnt=1, one frame completes; overrun_cnt forced to 0xFFFF plus another overrun -> stays 0xFFFF.
REQ-040 bus_rst pulsed while in REQ for channel 3 -> next cycle IDLE, src_req=0, no write; the next frame restarts at channel 0.
